reg_file: RTL and testbench

Eight-entry, 16-bit register file for the Simple RISC Machine datapath. It has one synchronous write port and one combinational read port. The write port is driven from the datapath writeback bus. The read port feeds the datapath operand latches. All registers clear asynchronously on reset.

---
 rtl/rf_pkg.sv | 6 +
 rtl/reg_file_reg_load.sv | 29 ++
 rtl/reg_file.sv | 57 +++++
 tb/tb_reg_file.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared sizing constants for the eight-entry SRM register file.
package rf_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int NREGS  = 8;
endpackage

// File: rtl/reg_file_reg_load.sv
// Single register with load enable and asynchronous active-high clear.
module reg_load
  import rf_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  // Storage element; reset wins over a coincident load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= {W{1'b0}};
    end else if (load) begin
      r_q <= d;
    end else begin
      r_q <= r_q;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/reg_file.sv
// Eight-entry register file: one synchronous write port, one combinational read port.
module reg_file #(
  parameter int DATA_W = rf_pkg::DATA_W,
  parameter int ADDR_W = rf_pkg::ADDR_W
) (
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] writenum,
  input  logic              write,
  input  logic [ADDR_W-1:0] readnum,
  input  logic              clk,
  output logic [DATA_W-1:0] data_out,
  input  logic              reset
);
  import rf_pkg::*;

  localparam int NR = 1 << ADDR_W;

  logic [NR-1:0]     w_wr_sel;
  logic [NR-1:0]     w_load_en;
  logic [NR-1:0]     w_rd_sel;
  logic [DATA_W-1:0] w_regs [NR];
  logic [DATA_W-1:0] w_rd_data;

  function automatic logic [NR-1:0] dec_onehot(input logic [ADDR_W-1:0] a);
    logic [NR-1:0] v;
    v = {NR{1'b0}};
    for (int i = 0; i < NR; i++) begin
      v[i] = (a == ADDR_W'(i));
    end
    return v;
  endfunction

  assign w_wr_sel  = dec_onehot(writenum);
  assign w_load_en = w_wr_sel & {NR{write}};
  assign w_rd_sel  = dec_onehot(readnum);

  for (genvar g = 0; g < NR; g++) begin : g_regs
    reg_load #(.W(DATA_W)) u_reg (
      .clk   (clk),
      .reset (reset),
      .load  (w_load_en[g]),
      .d     (data_in),
      .q     (w_regs[g])
    );
  end

  // One-hot AND-OR read mux; no write bypass, so reads see the pre-edge value.
  always_comb begin
    w_rd_data = {DATA_W{1'b0}};
    for (int i = 0; i < NR; i++) begin
      w_rd_data = w_rd_data | (w_regs[i] & {DATA_W{w_rd_sel[i]}});
    end
  end

  assign data_out = w_rd_data;

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file using a reference array and an expected-value queue.
module tb_reg_file;

  logic [15:0] data_in;
  logic [2:0]  writenum;
  logic        write;
  logic [2:0]  readnum;
  logic        clk;
  logic [15:0] data_out;
  logic        reset;

  logic [15:0] model [8];
  logic [15:0] sb_q [$];
  int          n_checks;
  int          n_pass;

  reg_file dut (
    .data_in  (data_in),
    .writenum (writenum),
    .write    (write),
    .readnum  (readnum),
    .clk      (clk),
    .data_out (data_out),
    .reset    (reset)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) model[i] = 16'h0000;
  endtask

  // Drive a write on the next rising edge and mirror it in the model.
  task automatic write_reg(input logic [2:0] n, input logic [15:0] d);
    @(negedge clk);
    write    = 1'b1;
    writenum = n;
    data_in  = d;
    @(posedge clk);
    #1;
    if (!reset) model[n] = d;
    write = 1'b0;
  endtask

  // Push expected value when the read is requested, pop and compare when data_out settles.
  task automatic read_chk(input string tag, input logic [2:0] n);
    sb_q.push_back(model[n]);
    readnum = n;
    #1;
    check_val(tag, data_out, sb_q.pop_front());
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    data_in  = 16'h0000;
    writenum = 3'd0;
    write    = 1'b0;
    readnum  = 3'd0;
    reset    = 1'b0;
    model_clear();
    #1 reset = 1'b1;
    #2;
    for (int i = 0; i < 8; i++) read_chk($sformatf("rst_hold_r%0d", i), 3'(i));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) read_chk($sformatf("rst_r%0d", i), 3'(i));

    write_reg(3'd0, 16'd5);
    write_reg(3'd1, 16'd7);
    write_reg(3'd7, 16'd12);
    read_chk("wr_r0", 3'd0);
    read_chk("wr_r1", 3'd1);
    read_chk("wr_r7", 3'd7);

    // write=0 must leave R1 alone
    @(negedge clk);
    write = 1'b0; data_in = 16'd3; writenum = 3'd1;
    @(posedge clk);
    #1;
    read_chk("nowr_r1", 3'd1);
    check_val("nowr_r1_lit", data_out, 16'd7);

    write_reg(3'd3, 16'hFFFF);
    read_chk("nbr_r2", 3'd2);
    read_chk("nbr_r4", 3'd4);
    read_chk("full_r3", 3'd3);
    check_val("full_r3_lit", data_out, 16'hFFFF);

    // Same-cycle read of the target returns old value, then new value right after the edge
    @(negedge clk);
    readnum = 3'd4; write = 1'b1; writenum = 3'd4; data_in = 16'hA5A5;
    #1;
    check_val("rbw_before", data_out, 16'h0000);
    @(posedge clk);
    #1;
    check_val("rbw_after", data_out, 16'hA5A5);
    model[4] = 16'hA5A5;
    data_in = 16'h1111;
    #1;
    write = 1'b0;
    @(posedge clk);
    #1;
    read_chk("mid_chg_r4", 3'd4);

    // Random traffic against the model
    for (int k = 0; k < 20; k++) begin
      write_reg(3'($urandom_range(0, 7)), 16'($urandom));
      read_chk($sformatf("rnd_%0d", k), 3'($urandom_range(0, 7)));
    end

    write_reg(3'd5, 16'h1234);
    read_chk("r5_load", 3'd5);
    @(negedge clk);
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    check_val("async_rst_r5", data_out, 16'h0000);
    write_reg(3'd6, 16'hBEEF);
    read_chk("rst_wr_r6", 3'd6);
    read_chk("rst_r0", 3'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    read_chk("post_rst_r5", 3'd5);
    write_reg(3'd0, 16'h0042);
    read_chk("post_rst_r0", 3'd0);
    read_chk("post_rst_r6", 3'd6);

    if (sb_q.size() != 0) begin
      check_val("sb_drain", 16'(sb_q.size()), 16'h0000);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
